pic_ack_sequencer: RTL and testbench

- Sits directly downstream of the pic block and consumes its int_out.
- Converts a pic interrupt into a CPU-side vector handshake: raises the CPU request, generates both intackN pulses, and reads ISR over the pic register port.
- Priority-encodes ISR into a vector and waits for CPU end-of-interrupt before issuing the second acknowledge.
- Enforces a settle gap between acknowledge sequences so back-to-back interrupts are handled cleanly.

---
 rtl/pic_ack_sequencer.sv | 148 ++++++++++++++
 tb/tb_pic_ack_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_sequencer.sv
// Turns a pic interrupt into a CPU vector handshake: irq, two intackN pulses, ISR read, EOI wait, settle gap.
// irq_out one edge after int_in; vec_valid holds vector/spurious until vec_ready; SERVICE stalls until cpu_eoi.
`ifndef SEL_OCR
`define SEL_OCR 2'b00
`endif
`ifndef SEL_ISR
`define SEL_ISR 2'b01
`endif
`ifndef RW_READ
`define RW_READ 1'b1
`endif

module pic_ack_sequencer #(
    parameter int ACK_WIDTH = 1,
    parameter int ACK_GAP = 1,
    parameter int READ_LAT = 1,
    parameter int SETTLE = 2,
    parameter logic [7:0] VEC_BASE = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_in,
    output logic       intackN,
    output logic [1:0] pic_select,
    output logic       pic_readwrite,
    input  logic [7:0] pic_rdata,
    output logic       irq_out,
    input  logic       cpu_ack,
    output logic       vec_valid,
    output logic [7:0] vector,
    output logic       spurious,
    input  logic       vec_ready,
    input  logic       cpu_eoi,
    output logic [7:0] serviced_cnt
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RAISE   = 4'd1;
    localparam logic [3:0] S_ACK1_LO = 4'd2;
    localparam logic [3:0] S_ACK1_HI = 4'd3;
    localparam logic [3:0] S_RD_ISR  = 4'd4;
    localparam logic [3:0] S_DELIVER = 4'd5;
    localparam logic [3:0] S_SERVICE = 4'd6;
    localparam logic [3:0] S_ACK2_LO = 4'd7;
    localparam logic [3:0] S_ACK2_HI = 4'd8;
    localparam logic [3:0] S_SETTLE  = 4'd9;

    localparam logic [7:0] LAST_W = 8'(ACK_WIDTH - 1);
    localparam logic [7:0] LAST_G = 8'(ACK_GAP - 1);
    localparam logic [7:0] LAST_R = 8'(READ_LAT - 1);
    localparam logic [7:0] LAST_S = 8'(SETTLE - 1);

    logic [3:0] state;
    logic [7:0] cnt;

    // Lowest set bit wins; an empty ISR maps to the lowest-priority slot.
    function automatic logic [7:0] isr_vector(input logic [7:0] isr);
        logic [7:0] v;
        v = VEC_BASE + 8'd7;
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) v = VEC_BASE + 8'(i);
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            intackN       <= 1'b1;
            pic_select    <= `SEL_OCR;
            pic_readwrite <= `RW_READ;
            irq_out       <= 1'b0;
            vec_valid     <= 1'b0;
            vector        <= 8'h00;
            spurious      <= 1'b0;
            serviced_cnt  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: if (int_in) begin
                    state   <= S_RAISE;
                    irq_out <= 1'b1;
                end
                S_RAISE: if (!int_in) begin
                    state   <= S_IDLE;
                    irq_out <= 1'b0;
                end else if (cpu_ack) begin
                    state   <= S_ACK1_LO;
                    irq_out <= 1'b0;
                    intackN <= 1'b0;
                    cnt     <= 8'd0;
                end
                S_ACK1_LO: if (cnt == LAST_W) begin
                    state   <= S_ACK1_HI;
                    intackN <= 1'b1;
                    cnt     <= 8'd0;
                end else cnt <= cnt + 8'd1;
                S_ACK1_HI: if (cnt == LAST_G) begin
                    state         <= S_RD_ISR;
                    pic_select    <= `SEL_ISR;
                    pic_readwrite <= `RW_READ;
                    cnt           <= 8'd0;
                end else cnt <= cnt + 8'd1;
                S_RD_ISR: if (cnt == LAST_R) begin
                    state      <= S_DELIVER;
                    pic_select <= `SEL_OCR;
                    vector     <= isr_vector(pic_rdata);
                    spurious   <= (pic_rdata == 8'h00);
                    vec_valid  <= 1'b1;
                    cnt        <= 8'd0;
                end else cnt <= cnt + 8'd1;
                S_DELIVER: if (vec_ready) begin
                    state     <= spurious ? S_SETTLE : S_SERVICE;
                    vec_valid <= 1'b0;
                    cnt       <= 8'd0;
                end
                S_SERVICE: if (cpu_eoi) begin
                    state   <= S_ACK2_LO;
                    intackN <= 1'b0;
                    cnt     <= 8'd0;
                end
                S_ACK2_LO: if (cnt == LAST_W) begin
                    state   <= S_ACK2_HI;
                    intackN <= 1'b1;
                    cnt     <= 8'd0;
                end else cnt <= cnt + 8'd1;
                S_ACK2_HI: if (cnt == LAST_G) begin
                    state        <= S_SETTLE;
                    serviced_cnt <= serviced_cnt + 8'd1;
                    cnt          <= 8'd0;
                end else cnt <= cnt + 8'd1;
                S_SETTLE: if (cnt == LAST_S) begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end else cnt <= cnt + 8'd1;
                default: begin
                    state      <= S_IDLE;
                    cnt        <= 8'd0;
                    intackN    <= 1'b1;
                    pic_select <= `SEL_OCR;
                    irq_out    <= 1'b0;
                    vec_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed plus randomized checks of pic_ack_sequencer against a spec-level model of vectors, pulse counts and timing.
`ifndef SEL_OCR
`define SEL_OCR 2'b00
`endif
`ifndef SEL_ISR
`define SEL_ISR 2'b01
`endif
`ifndef RW_READ
`define RW_READ 1'b1
`endif

module tb_pic_ack_sequencer;

    localparam logic [7:0] VEC_BASE = 8'h20;
    localparam int SETTLE = 2;

    logic       clk, reset, int_in, cpu_ack, vec_ready, cpu_eoi;
    logic [7:0] pic_rdata;
    logic       intackN, pic_readwrite, irq_out, vec_valid, spurious;
    logic [1:0] pic_select;
    logic [7:0] vector, serviced_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int low_cycles = 0, pulses = 0, sel_cycles = 0;
    logic prev_ack = 1'b1;
    logic [7:0] svc_model = 8'h00;
    int total_svc = 0;
    int rise_cyc = 0, done_cyc = 0;

    pic_ack_sequencer dut (
        .clk(clk), .reset(reset), .int_in(int_in), .intackN(intackN),
        .pic_select(pic_select), .pic_readwrite(pic_readwrite), .pic_rdata(pic_rdata),
        .irq_out(irq_out), .cpu_ack(cpu_ack), .vec_valid(vec_valid), .vector(vector),
        .spurious(spurious), .vec_ready(vec_ready), .cpu_eoi(cpu_eoi),
        .serviced_cnt(serviced_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (!intackN) low_cycles = low_cycles + 1;
            if (!intackN && prev_ack) pulses = pulses + 1;
            if (pic_select == `SEL_ISR) sel_cycles = sel_cycles + 1;
        end
        prev_ack = intackN;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector from the lowest set ISR bit, computed by isolating that bit arithmetically.
    function automatic logic [7:0] model_vec(input logic [7:0] isr);
        logic [7:0] low;
        if (isr == 8'h00) return VEC_BASE + 8'd7;
        low = isr & (~isr + 8'd1);
        return VEC_BASE + 8'($clog2(low));
    endfunction

    task automatic service(input logic [7:0] isr, input int stall, input bit hold);
        int lo0, pl0, sel0, n, npulse;
        logic [7:0] ev;
        logic es;
        es = (isr == 8'h00);
        ev = model_vec(isr);
        npulse = es ? 1 : 2;
        pic_rdata = isr;
        lo0 = low_cycles; pl0 = pulses; sel0 = sel_cycles;
        int_in = 1'b1;
        step;
        n = 1;
        while (!irq_out && n < 20) begin step; n++; end
        chk("irq_rise", 32'(irq_out), 32'd1);
        rise_cyc = cyc;
        cpu_ack = 1'b1;
        step;
        cpu_ack = 1'b0;
        chk("irq_drop_on_ack", 32'(irq_out), 32'd0);
        if (!hold) int_in = 1'b0;
        n = 0;
        while (!vec_valid && n < 20) begin step; n++; end
        chk("ack_to_vec_edges", 32'(n), 32'd3);
        chk("vector", 32'(vector), 32'(ev));
        chk("spurious", 32'(spurious), 32'(es));
        vec_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step;
            chk("stall_valid", 32'(vec_valid), 32'd1);
            chk("stall_vector", 32'(vector), 32'(ev));
        end
        vec_ready = 1'b1;
        step;
        vec_ready = 1'b0;
        chk("vec_valid_clear", 32'(vec_valid), 32'd0);
        if (!es) begin
            step;
            cpu_eoi = 1'b1;
            step;
            cpu_eoi = 1'b0;
            n = 0;
            while (serviced_cnt == svc_model && n < 20) begin step; n++; end
            svc_model = svc_model + 8'd1;
            total_svc++;
            done_cyc = cyc;
            chk("eoi_to_count_edges", 32'(n), 32'd2);
            chk("serviced_cnt", 32'(serviced_cnt), 32'(svc_model));
        end else begin
            cpu_eoi = 1'b1;
            step;
            cpu_eoi = 1'b0;
            repeat (3) step;
            chk("spurious_cnt_hold", 32'(serviced_cnt), 32'(svc_model));
        end
        chk("intack_pulses", 32'(pulses - pl0), 32'(npulse));
        chk("intack_low_cycles", 32'(low_cycles - lo0), 32'(npulse));
        chk("isr_select_cycles", 32'(sel_cycles - sel0), 32'd1);
        if (!hold) begin
            int_in = 1'b0;
            repeat (SETTLE + 1) step;
        end
    endtask

    initial begin
        int lo0, prev_done;
        logic [7:0] isr;
        reset = 1'b1; int_in = 1'b0; cpu_ack = 1'b0; vec_ready = 1'b0;
        cpu_eoi = 1'b0; pic_rdata = 8'h00;
        step; step;
        chk("rst_intackN", 32'(intackN), 32'd1);
        chk("rst_select", 32'(pic_select), 32'(`SEL_OCR));
        chk("rst_rw", 32'(pic_readwrite), 32'(`RW_READ));
        chk("rst_irq", 32'(irq_out), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_vector", 32'(vector), 32'h00);
        chk("rst_count", 32'(serviced_cnt), 32'h00);
        reset = 1'b0;
        step;

        service(8'h04, 0, 1'b0);
        service(8'h05, 0, 1'b1);
        prev_done = done_cyc;
        service(8'h04, 0, 1'b0);
        chk("settle_gap_ok", 32'((rise_cyc - prev_done) >= SETTLE + 1), 32'd1);
        service(8'h00, 0, 1'b0);

        lo0 = low_cycles;
        int_in = 1'b1;
        step;
        chk("withdraw_irq_up", 32'(irq_out), 32'd1);
        step; step;
        int_in = 1'b0;
        cpu_ack = 1'b0;
        step;
        chk("withdraw_irq_down", 32'(irq_out), 32'd0);
        repeat (3) step;
        chk("withdraw_no_intack", 32'(low_cycles - lo0), 32'd0);

        service(8'h10, 5, 1'b0);

        pic_rdata = 8'h02;
        int_in = 1'b1;
        step;
        cpu_ack = 1'b1;
        step;
        chk("ack1_low_before_reset", 32'(intackN), 32'd0);
        cpu_ack = 1'b0; int_in = 1'b0; reset = 1'b1;
        step;
        chk("midrst_intackN", 32'(intackN), 32'd1);
        chk("midrst_irq", 32'(irq_out), 32'd0);
        chk("midrst_vec_valid", 32'(vec_valid), 32'd0);
        chk("midrst_count", 32'(serviced_cnt), 32'h00);
        step;
        reset = 1'b0;
        svc_model = 8'h00;
        total_svc = 0;
        step; step;
        chk("post_rst_idle_irq", 32'(irq_out), 32'd0);
        chk("post_rst_intackN", 32'(intackN), 32'd1);

        while (total_svc < 256) begin
            isr = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            service(isr, int'($urandom_range(0, 2)), 1'b0);
        end
        chk("count_wrap", 32'(serviced_cnt), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
